abs_diff_et_checker: RTL
========================

ABS_DIFF_ET_CHECKER -- requirements
Module: abs_diff_et_checker

Interface
REQ-001 The block SHALL have parameter N_IN, default 4: DUT input count, even; operand a = dut_in[N_IN/2-1:0], operand b = dut_in[N_IN-1:N_IN/2].
REQ-002 The block SHALL have parameter N_OUT, default 2: DUT output width, N_OUT >= N_IN/2.
REQ-003 The block SHALL have parameter ET, default 1: error threshold, unsigned, N_OUT bits.
REQ-004 The block SHALL have parameter SETTLE, default 1: extra cycles each vector is held before sampling, >= 0.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port start, input, 1 bit: request one exhaustive sweep.
REQ-008 The block SHALL have port dut_in, output, N_IN bits: stimulus vector to the combinational approximate circuit (in0 = bit 0).
REQ-009 The block SHALL have port dut_out, input, N_OUT bits: response of the approximate circuit (out0 = bit 0).
REQ-010 The block SHALL have port busy, output, 1 bit: sweep in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse at sweep end.
REQ-012 The block SHALL have port pass, output, 1 bit: max_err <= ET; valid from done until the next accepted start.
REQ-013 The block SHALL have port max_err, output, N_OUT bits: largest per-vector error of the sweep.
REQ-014 The block SHALL have port err_cnt, output, N_IN+1 bits: number of vectors with nonzero error.
REQ-015 The block SHALL have port fail_vec, output, N_IN bits: first vector whose error exceeds ET; 0 if none.

Function
REQ-016 The FSM SHALL have states IDLE, APPLY, SAMPLE, FINISH; in IDLE, start=1 at a rising edge SHALL clear max_err, err_cnt, fail_vec, pass and enter APPLY with dut_in=0.
REQ-017 start SHALL be ignored while busy=1; busy SHALL be 1 in APPLY and SAMPLE only.
REQ-018 Each vector v SHALL be held on dut_in for exactly SETTLE+1 cycles (SETTLE cycles in APPLY, then 1 in SAMPLE); dut_out SHALL be sampled at the edge ending SAMPLE.
REQ-019 The exact reference SHALL be |a-b| computed on N_IN/2-bit unsigned operands, zero-extended to N_OUT bits; per-vector error SHALL be |dut_out - exact|, unsigned, N_OUT bits, no wrap.
REQ-020 At each sample: err_cnt increments when error != 0; max_err = max(max_err, error); fail_vec latches v only on the first vector with error > ET.
REQ-021 After sampling v = 2^N_IN-1 the FSM SHALL enter FINISH; counters SHALL NOT wrap the vector index back to 0 within a sweep.
REQ-022 In FINISH, done=1 for exactly one cycle, pass=(max_err <= ET), then IDLE; dut_in SHALL return to 0.
REQ-023 With start accepted at edge k, done SHALL be high in the cycle after edge k + 2^N_IN*(SETTLE+1) (defaults: 32 edges).
REQ-024 ET=0 SHALL mean exact-equivalence check; ET >= 2^N_OUT-1 SHALL always pass.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, dut_in=0, busy=0, done=0, pass=0, max_err=0, err_cnt=0, fail_vec=0, regardless of clk.
REQ-026 rst asserted mid-sweep SHALL abandon the sweep with no done pulse; the next start SHALL run a full sweep from vector 0.

Configuration
REQ-027 With macro ABS_DIFF_CHK_EARLY_ABORT_EN defined, the first vector with error > ET SHALL end the sweep: next state FINISH, pass=0, statistics covering vectors 0..v only.
REQ-028 Without ABS_DIFF_CHK_EARLY_ABORT_EN, all 2^N_IN vectors SHALL always be swept.

Verification
REQ-029 Defaults, DUT model = exact |a-b|, start pulse -> done 32 edges later, pass=1, max_err=0, err_cnt=0, fail_vec=0.
REQ-030 Defaults, DUT tied to 0 -> max_err=3, err_cnt=12, fail_vec=2, pass=0.
REQ-031 Defaults, DUT = exact XOR 1 -> err_cnt=16, max_err=1, fail_vec=0, pass=1.
REQ-032 rst pulsed while dut_in=5 -> all outputs 0 at once, no done; new start -> full 32-edge sweep with correct results.
REQ-033 ABS_DIFF_CHK_EARLY_ABORT_EN defined, DUT tied to 0 -> done after vector 2 (edge k+6), err_cnt=2, max_err=2, fail_vec=2, pass=0.
REQ-034 start held high for the whole sweep -> exactly one sweep per IDLE entry, no extra done pulse mid-sweep.

Source files
------------

// File: rtl/abs_diff_et_checker.sv
// abs_diff_et_checker: exhaustive error-threshold sweep of an approximate |a-b| circuit.
// Define ABS_DIFF_CHK_EARLY_ABORT_EN to end the sweep at the first vector whose error exceeds ET.
module abs_diff_et_checker #(
  parameter int N_IN = 4,
  parameter int N_OUT = 2,
  parameter logic [N_OUT-1:0] ET = N_OUT'(1),
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_OUT-1:0] max_err,
  output logic [N_IN:0]    err_cnt,
  output logic [N_IN-1:0]  fail_vec
);
  localparam int H = N_IN / 2;
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] CMAX = SW'(SETTLE > 0 ? SETTLE - 1 : 0);
`ifdef ABS_DIFF_CHK_EARLY_ABORT_EN
  localparam bit EA = 1'b1;
`else
  localparam bit EA = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, FINISH} state_t;
  // With no settle time a vector goes straight to its sampling cycle
  localparam state_t HOLD = SETTLE > 0 ? APPLY : SAMPLE;
  state_t state, nxt;
  logic [SW-1:0] cnt;
  logic seen;
  logic [H-1:0] a, b;
  logic [N_OUT-1:0] exact, err, max_n;
  logic bad, stop;
  assign a = dut_in[H-1:0];
  assign b = dut_in[N_IN-1:H];
  always_comb begin
    exact = N_OUT'(a > b ? a - b : b - a);
    err = dut_out > exact ? dut_out - exact : exact - dut_out;
    max_n = err > max_err ? err : max_err;
    bad = err > ET;
    stop = (&dut_in) || (EA && bad);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? HOLD : IDLE;
      APPLY:   nxt = cnt == CMAX ? SAMPLE : APPLY;
      SAMPLE:  nxt = stop ? FINISH : HOLD;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state == APPLY || state == SAMPLE;
    done = state == FINISH;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dut_in <= '0;
      cnt <= '0;
      seen <= 1'b0;
      pass <= 1'b0;
      max_err <= '0;
      err_cnt <= '0;
      fail_vec <= '0;
    end else begin
      cnt <= state == APPLY ? cnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        dut_in <= '0;
        seen <= 1'b0;
        pass <= 1'b0;
        max_err <= '0;
        err_cnt <= '0;
        fail_vec <= '0;
      end
      if (state == SAMPLE) begin
        dut_in <= stop ? '0 : dut_in + 1'b1;
        max_err <= max_n;
        if (err != '0) err_cnt <= err_cnt + 1'b1;
        if (bad && !seen) begin
          fail_vec <= dut_in;
          seen <= 1'b1;
        end
        if (stop) pass <= max_n <= ET;
      end
    end
endmodule
